// File: rtl/candle_pkg.sv
// Shared constants, FSM state encoding and helpers for the candle command sequencer.
package candle_pkg;

   localparam int unsigned NUM_CANDLES = 8;
   localparam int unsigned POS_W       = 3;
   localparam int unsigned CNT_W       = 4;

   localparam logic OP_LIGHT = 1'b1;
   localparam logic OP_BLOW  = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LIGHT  = 3'd1,
      ST_BLOW   = 3'd2,
      ST_PACE   = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Requests larger than the candle count saturate to the candle count
   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
      return (cnt > CNT_W'(NUM_CANDLES)) ? CNT_W'(NUM_CANDLES) : cnt;
   endfunction

endpackage

// File: rtl/candle_find_pos.sv
// Combinational search: lowest unlit and highest lit candle of an 8-bit state vector.
module candle_find_pos
   import candle_pkg::*;
(
   input  logic [NUM_CANDLES-1:0] vec,
   output logic [POS_W-1:0]       low_zero_c,
   output logic                   zero_found_c,
   output logic [POS_W-1:0]       high_one_c,
   output logic                   one_found_c
);

   always_comb begin
      low_zero_c   = '0;
      zero_found_c = 1'b0;
      high_one_c   = '0;
      one_found_c  = 1'b0;
      // Descending scan leaves the lowest zero as the final hit
      for (int i = NUM_CANDLES - 1; i >= 0; i--) begin
         if (!vec[i]) begin
            low_zero_c   = POS_W'(i);
            zero_found_c = 1'b1;
         end
      end
      for (int i = 0; i < NUM_CANDLES; i++) begin
         if (vec[i]) begin
            high_one_c  = POS_W'(i);
            one_found_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/candle_cmd_sequencer.sv
// Turns light/blow requests into per-candle set/clear commands against a shadow of candle state.
// Optional pacing between commands is enabled with macro CANDLE_PACE_EN.
module candle_cmd_sequencer
   import candle_pkg::*;
#(
   parameter int unsigned PACE_CYCLES = 4
) (
   input  logic             sys_clk,
   input  logic             clr_async_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic [CNT_W-1:0] req_count,
   output logic [POS_W-1:0] pos_to_set,
   output logic             set_enable,
   output logic [POS_W-1:0] pos_to_clear,
   output logic             clear_enable,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] applied_count
);

`ifdef CANDLE_PACE_EN
   localparam bit PACE_ON = 1'b1;
`else
   localparam bit PACE_ON = 1'b0;
`endif

   state_t                 state_q, state_d;
   logic [NUM_CANDLES-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]       rem_q, rem_d;
   logic [CNT_W-1:0]       issued_q, issued_d;
   logic [CNT_W-1:0]       pace_q, pace_d;
   logic                   op_q, op_d;
   logic [CNT_W-1:0]       applied_d;
   logic [POS_W-1:0]       pos_set_d, pos_clr_d;
   logic                   set_en_d, clr_en_d, done_d;

   logic                   want_cmd, cmd_op, eligible;
   logic [CNT_W-1:0]       cmd_rem, base_cnt;
   logic [POS_W-1:0]       low_zero, high_one;
   logic                   zero_found, one_found;

   candle_find_pos u_find (
      .vec          (shadow_q),
      .low_zero_c   (low_zero),
      .zero_found_c (zero_found),
      .high_one_c   (high_one),
      .one_found_c  (one_found)
   );

   // Next state plus next values of every registered output
   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      rem_d     = rem_q;
      issued_d  = issued_q;
      pace_d    = pace_q;
      op_d      = op_q;
      applied_d = applied_count;
      pos_set_d = '0;
      pos_clr_d = '0;
      set_en_d  = 1'b0;
      clr_en_d  = 1'b0;
      done_d    = 1'b0;
      want_cmd  = 1'b0;
      cmd_op    = op_q;
      cmd_rem   = rem_q;
      base_cnt  = issued_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               want_cmd = 1'b1;
               cmd_op   = req_op;
               cmd_rem  = sat_count(req_count);
               base_cnt = '0;
               op_d     = req_op;
               issued_d = '0;
            end
         end
         ST_LIGHT, ST_BLOW: want_cmd = 1'b1;
         ST_PACE: begin
            if (pace_q == '0) want_cmd = 1'b1;
            else              pace_d   = pace_q - CNT_W'(1);
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      eligible = (cmd_op == OP_LIGHT) ? zero_found : one_found;

      if (want_cmd) begin
         if ((cmd_rem != '0) && eligible) begin
            if (PACE_ON && (state_q == ST_LIGHT || state_q == ST_BLOW)) begin
               state_d = ST_PACE;
               pace_d  = CNT_W'(PACE_CYCLES - 1);
            end else begin
               rem_d    = cmd_rem - CNT_W'(1);
               issued_d = base_cnt + CNT_W'(1);
               if (cmd_op == OP_LIGHT) begin
                  state_d            = ST_LIGHT;
                  set_en_d           = 1'b1;
                  pos_set_d          = low_zero;
                  shadow_d[low_zero] = 1'b1;
               end else begin
                  state_d            = ST_BLOW;
                  clr_en_d           = 1'b1;
                  pos_clr_d          = high_one;
                  shadow_d[high_one] = 1'b0;
               end
            end
         end else begin
            state_d   = ST_FINISH;
            done_d    = 1'b1;
            applied_d = base_cnt;
            rem_d     = '0;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge clr_async_n) begin
      if (!clr_async_n) begin
         state_q       <= ST_IDLE;
         shadow_q      <= '0;
         rem_q         <= '0;
         issued_q      <= '0;
         pace_q        <= '0;
         op_q          <= OP_BLOW;
         applied_count <= '0;
         pos_to_set    <= '0;
         pos_to_clear  <= '0;
         set_enable    <= 1'b0;
         clear_enable  <= 1'b0;
         done          <= 1'b0;
         busy          <= 1'b0;
         req_ready     <= 1'b1;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         rem_q         <= rem_d;
         issued_q      <= issued_d;
         pace_q        <= pace_d;
         op_q          <= op_d;
         applied_count <= applied_d;
         pos_to_set    <= pos_set_d;
         pos_to_clear  <= pos_clr_d;
         set_enable    <= set_en_d;
         clear_enable  <= clr_en_d;
         done          <= done_d;
         busy          <= (state_d != ST_IDLE);
         req_ready     <= (state_d == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_candle_cmd_sequencer.sv
// Randomized self-checking bench for candle_cmd_sequencer against a candle-list reference model.
module tb_candle_cmd_sequencer;

   localparam int unsigned TB_PACE = 2;

   logic       sys_clk = 1'b0;
   logic       clr_async_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_op = 1'b0;
   logic [3:0] req_count = '0;
   logic       req_ready, set_enable, clear_enable, busy, done;
   logic [2:0] pos_to_set, pos_to_clear;
   logic [3:0] applied_count;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] model_shadow = '0;
   int         pace_gap;

   candle_cmd_sequencer #(.PACE_CYCLES(TB_PACE)) dut (
      .sys_clk       (sys_clk),
      .clr_async_n   (clr_async_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_count     (req_count),
      .pos_to_set    (pos_to_set),
      .set_enable    (set_enable),
      .pos_to_clear  (pos_to_clear),
      .clear_enable  (clear_enable),
      .busy          (busy),
      .done          (done),
      .applied_count (applied_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic test_reset();
      logic [12:0] obs;
      clr_async_n = 1'b0;
      req_valid   = 1'b0;
      repeat (2) @(negedge sys_clk);
      obs = {set_enable, clear_enable, pos_to_set, pos_to_clear, busy, done, applied_count};
      checks++;
      if (obs !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want %b", obs, 13'd0);
      end
      clr_async_n  = 1'b1;
      model_shadow = '0;
      @(negedge sys_clk);
      checks++;
      if ({req_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_release_ready: got ready/busy %b want 10", {req_ready, busy});
      end
   endtask

   // Issue one request and check every cycle until one idle cycle after done
   task automatic run_req(input string name, input logic op, input logic [3:0] cnt, input bit noise);
      int         cmds[$];
      logic [9:0] exp_q[$];
      logic [7:0] sh;
      int         lim, p, n;
      logic [9:0] obs, expv;

      sh  = model_shadow;
      lim = (cnt > 8) ? 8 : int'(cnt);
      for (int k = 0; k < lim; k++) begin
         p = -1;
         if (op) begin
            for (int i = 0; i < 8; i++) if (!sh[i] && p < 0) p = i;
         end else begin
            for (int i = 7; i >= 0; i--) if (sh[i] && p < 0) p = i;
         end
         if (p < 0) break;
         sh[p] = op;
         cmds.push_back(p);
      end
      n = cmds.size();

      // Expected vector: {busy, done, set_en, clr_en, pos_set, pos_clr}
      for (int k = 0; k < n; k++) begin
         if (op) exp_q.push_back({4'b1010, 3'(cmds[k]), 3'd0});
         else    exp_q.push_back({4'b1001, 3'd0, 3'(cmds[k])});
         if (k < n - 1) for (int g = 0; g < pace_gap; g++) exp_q.push_back(10'b10_0000_0000);
      end
      exp_q.push_back(10'b11_0000_0000);

      @(negedge sys_clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready: got %b want 1", name, req_ready);
      end
      req_valid = 1'b1;
      req_op    = op;
      req_count = cnt;
      @(posedge sys_clk);

      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge sys_clk);
         if (noise && c < exp_q.size() - 1) begin
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 1'($urandom_range(0, 1));
            req_count = 4'($urandom_range(0, 15));
         end else begin
            req_valid = 1'b0;
         end
         obs  = {busy, done, set_enable, clear_enable, pos_to_set, pos_to_clear};
         expv = exp_q[c];
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s_cycle%0d: got %b want %b", name, c + 1, obs, expv);
         end
         if (c == exp_q.size() - 1) begin
            checks++;
            if (applied_count !== 4'(n)) begin
               errors++;
               $display("FAIL %s_applied: got %0d want %0d", name, applied_count, n);
            end
         end
      end

      @(negedge sys_clk);
      obs = {busy, done, set_enable, clear_enable, pos_to_set, pos_to_clear};
      checks++;
      if (obs !== 10'd0 || req_ready !== 1'b1 || applied_count !== 4'(n)) begin
         errors++;
         $display("FAIL %s_idle: got %b rdy %b app %0d want %b rdy 1 app %0d",
                  name, obs, req_ready, applied_count, 10'd0, n);
      end
      model_shadow = sh;
   endtask

   task automatic test_reset_mid();
      logic [3:0] obs;
      test_reset();
      @(negedge sys_clk);
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_count = 4'd5;
      @(posedge sys_clk);
      @(negedge sys_clk);
      req_valid = 1'b0;
      checks++;
      if ({set_enable, pos_to_set} !== 4'b1000) begin
         errors++;
         $display("FAIL mid_first_cmd: got %b want 1000", {set_enable, pos_to_set});
      end
      @(posedge sys_clk);
      #1 clr_async_n = 1'b0;
      #1 obs = {set_enable, clear_enable, busy, done};
      checks++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_immediate: got %b want 0000", obs);
      end
      model_shadow = '0;
      @(negedge sys_clk);
      clr_async_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge sys_clk);
         obs = {set_enable, clear_enable, done, req_ready};
         checks++;
         if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL mid_after_release%0d: got %b want 0001", c, obs);
         end
      end
   endtask

   task automatic test_random();
      logic       op;
      logic [3:0] cnt;
      for (int r = 0; r < 40; r++) begin
         op  = 1'($urandom_range(0, 1));
         cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         run_req("rand", op, cnt, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
`ifdef CANDLE_PACE_EN
      pace_gap = TB_PACE;
`else
      pace_gap = 0;
`endif
      test_reset();
      run_req("light3", 1'b1, 4'd3, 1'b0);
      run_req("light_sat", 1'b1, 4'd15, 1'b0);
      run_req("all_lit", 1'b1, 4'd2, 1'b1);
      run_req("count_zero", 1'b0, 4'd0, 1'b0);
      run_req("blow_sat", 1'b0, 4'd15, 1'b1);
      run_req("none_lit", 1'b0, 4'd3, 1'b0);
      run_req("light2", 1'b1, 4'd2, 1'b1);
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
